// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
package stopwatch_pkg;

    localparam int unsigned HOUR_W    = 6;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned SEC_W     = 6;
    localparam int unsigned MSEC_W    = 7;
    localparam int unsigned LAP_CNT_W = 4;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned CLEAR_CYCLES_DEF    = 4;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_LAP     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_CLEAR   = 3'd4
    } sw_state_e;

    // One complete time value; all fields move together
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchroniser, stable-level debounce, press-edge pulse.
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset (state returns to "released")
//   key      raw key level, asynchronous to clock
//   press    one-clock pulse on an accepted released->pressed transition
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pressed_c;
    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Normalise polarity so that 1 always means "pressed"
    assign pressed_c = KEY_ACTIVE_LOW ? ~key : key;

    // Synchroniser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pressed_c;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the accepted level restarts the stability count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_q2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pulse only on the accepted press edge; release is silent
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule : key_debounce

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounced start/stop and lap/reset keys drive a
// run/lap/pause/clear sequencer, capture lap snapshots and select the displayed time.
// Ports:
//   clock, reset_n                         clock, asynchronous active-low reset
//   key_start, key_lap                     raw keys, asynchronous to clock
//   hour_in/minute_in/second_in/msec_in    live time from the counter
//   run, clear                             counter enable and clear (registered)
//   hour_out/minute_out/second_out/msec_out displayed time (registered, live or snapshot)
//   lap_active                             display is showing a snapshot
//   lap_count                              laps since last clear, modulo 16
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CLEAR_CYCLES    = CLEAR_CYCLES_DEF,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 key_start,
    input  logic                 key_lap,
    input  logic [HOUR_W-1:0]    hour_in,
    input  logic [MIN_W-1:0]     minute_in,
    input  logic [SEC_W-1:0]     second_in,
    input  logic [MSEC_W-1:0]    msec_in,
    output logic                 run,
    output logic                 clear,
    output logic [HOUR_W-1:0]    hour_out,
    output logic [MIN_W-1:0]     minute_out,
    output logic [SEC_W-1:0]     second_out,
    output logic [MSEC_W-1:0]    msec_out,
    output logic                 lap_active,
    output logic [LAP_CNT_W-1:0] lap_count
);

    localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    logic                 start_press;
    logic                 lap_press;

    sw_state_e            state;
    sw_state_e            state_next;
    logic [CLR_W-1:0]     clear_cnt;
    logic [CLR_W-1:0]     clear_cnt_next;
    logic [LAP_CNT_W-1:0] lap_count_next;
    sw_time_t             snap_q;
    sw_time_t             snap_next;
    sw_time_t             live_c;
    sw_time_t             disp_q;
    sw_time_t             disp_next;
    logic                 run_next;
    logic                 clear_next;
    logic                 lap_active_next;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_deb_start (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (key_start),
        .press   (start_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_deb_lap (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (key_lap),
        .press   (lap_press)
    );

    assign live_c = '{hour: hour_in, minute: minute_in, second: second_in, msec: msec_in};

    // Next state, lap bookkeeping and next registered outputs
    always_comb begin
        state_next      = state;
        clear_cnt_next  = clear_cnt;
        lap_count_next  = lap_count;
        snap_next       = snap_q;
        run_next        = 1'b0;
        clear_next      = 1'b0;
        lap_active_next = 1'b0;
        disp_next       = live_c;

        // start is checked first everywhere, so a coincident lap pulse is dropped
        case (state)
            ST_IDLE: begin
                if (start_press)    state_next = ST_RUNNING;
                else if (lap_press) state_next = ST_CLEAR;
            end
            ST_RUNNING: begin
                if (start_press) begin
                    state_next = ST_PAUSED;
                end else if (lap_press) begin
                    state_next     = ST_LAP;
                    snap_next      = live_c;
                    lap_count_next = lap_count + LAP_CNT_W'(1);
                end
            end
            ST_LAP: begin
                if (start_press)    state_next = ST_PAUSED;
                else if (lap_press) state_next = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (start_press)    state_next = ST_RUNNING;
                else if (lap_press) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Keys are ignored here; only the timer moves the FSM on
                if (clear_cnt == CLR_LAST) begin
                    state_next     = ST_IDLE;
                    clear_cnt_next = '0;
                end else begin
                    clear_cnt_next = clear_cnt + CLR_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next == ST_CLEAR) begin
            lap_count_next = '0;
            snap_next      = '0;
        end

        run_next        = (state_next == ST_RUNNING) || (state_next == ST_LAP);
        clear_next      = (state_next == ST_CLEAR);
        lap_active_next = (state_next == ST_LAP);
        if (lap_active_next) disp_next = snap_next;
    end

    // State and control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            clear_cnt  <= '0;
            lap_count  <= '0;
            snap_q     <= '0;
            run        <= 1'b0;
            clear      <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_next;
            clear_cnt  <= clear_cnt_next;
            lap_count  <= lap_count_next;
            snap_q     <= snap_next;
            run        <= run_next;
            clear      <= clear_next;
            lap_active <= lap_active_next;
        end
    end

    // Display register is deliberately unreset so it keeps tracking live time during reset
    always_ff @(posedge clock) begin
        disp_q <= disp_next;
    end

    assign hour_out   = disp_q.hour;
    assign minute_out = disp_q.minute;
    assign second_out = disp_q.second;
    assign msec_out   = disp_q.msec;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce and clear timers.
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_start;
    logic       key_lap;
    logic [5:0] hour_in;
    logic [5:0] minute_in;
    logic [5:0] second_in;
    logic [6:0] msec_in;
    logic       run;
    logic       clear;
    logic [5:0] hour_out;
    logic [5:0] minute_out;
    logic [5:0] second_out;
    logic [6:0] msec_out;
    logic       lap_active;
    logic [3:0] lap_count;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CLEAR_CYCLES    (3),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_start  (key_start),
        .key_lap    (key_lap),
        .hour_in    (hour_in),
        .minute_in  (minute_in),
        .second_in  (second_in),
        .msec_in    (msec_in),
        .run        (run),
        .clear      (clear),
        .hour_out   (hour_out),
        .minute_out (minute_out),
        .second_out (second_out),
        .msec_out   (msec_out),
        .lap_active (lap_active),
        .lap_count  (lap_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press selected keys until the FSM reacts (8 clocks), then release and let it settle
    task automatic hit(input logic s, input logic l);
        if (s) key_start = 1'b0;
        if (l) key_lap   = 1'b0;
        tick(8);
        key_start = 1'b1;
        key_lap   = 1'b1;
        tick(8);
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [6:0] ms);
        hour_in   = h;
        minute_in = m;
        second_in = s;
        msec_in   = ms;
    endtask

    // run and clear must never be high together
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            checks++;
            assert (!(run && clear)) else begin
                failures++;
                $error("FAIL run_clear_excl observed=%0d expected=0", run && clear);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        key_start = 1'b1;
        key_lap   = 1'b1;
        set_time(6'd5, 6'd6, 6'd7, 7'd8);

        // Reset state; display tracks inputs while reset is held
        tick(2);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_clear", 32'(clear), 32'd0);
        chk("rst_lap_active", 32'(lap_active), 32'd0);
        chk("rst_lap_count", 32'(lap_count), 32'd0);
        chk("rst_hour_live", 32'(hour_out), 32'd5);
        chk("rst_msec_live", 32'(msec_out), 32'd8);
        reset_n = 1'b1;
        tick(2);

        // Bounce on start key, then held: one press, run 8 clocks after the last edge
        set_time(6'd0, 6'd1, 6'd2, 7'd37);
        for (int i = 0; i < 10; i++) begin
            key_start = ~key_start;
            tick(2);
        end
        chk("bounce_no_press", 32'(run), 32'd0);
        key_start = 1'b0;
        tick(7);
        chk("bounce_run_early", 32'(run), 32'd0);
        tick(1);
        chk("bounce_run", 32'(run), 32'd1);
        chk("bounce_live_msec", 32'(msec_out), 32'd37);
        chk("bounce_lap_active", 32'(lap_active), 32'd0);
        tick(20);
        chk("hold_single_pulse", 32'(run), 32'd1);
        key_start = 1'b1;
        tick(10);
        chk("release_no_pulse", 32'(run), 32'd1);

        // Lap snapshot freezes the display while inputs advance
        hit(1'b0, 1'b1);
        chk("lap_active", 32'(lap_active), 32'd1);
        chk("lap_run", 32'(run), 32'd1);
        chk("lap_count1", 32'(lap_count), 32'd1);
        chk("lap_hour", 32'(hour_out), 32'd0);
        chk("lap_minute", 32'(minute_out), 32'd1);
        chk("lap_second", 32'(second_out), 32'd2);
        chk("lap_msec", 32'(msec_out), 32'd37);
        set_time(6'd0, 6'd1, 6'd3, 7'd50);
        tick(2);
        chk("lap_frozen_second", 32'(second_out), 32'd2);
        chk("lap_frozen_msec", 32'(msec_out), 32'd37);
        hit(1'b0, 1'b1);
        chk("unlap_active", 32'(lap_active), 32'd0);
        chk("unlap_second", 32'(second_out), 32'd3);
        chk("unlap_msec", 32'(msec_out), 32'd50);
        chk("unlap_run", 32'(run), 32'd1);
        chk("unlap_count", 32'(lap_count), 32'd1);

        // Both keys together in RUNNING: start wins, no snapshot
        set_time(6'd0, 6'd2, 6'd4, 7'd11);
        hit(1'b1, 1'b1);
        chk("simul_run", 32'(run), 32'd0);
        chk("simul_lap_active", 32'(lap_active), 32'd0);
        chk("simul_lap_count", 32'(lap_count), 32'd1);
        chk("simul_live_msec", 32'(msec_out), 32'd11);

        // Resume and pause again
        hit(1'b1, 1'b0);
        chk("resume_run", 32'(run), 32'd1);
        hit(1'b1, 1'b0);
        chk("pause_run", 32'(run), 32'd0);

        // Clear from PAUSED: exactly 3 clocks, start during clear ignored
        key_lap = 1'b0;
        tick(2);
        key_start = 1'b0;
        tick(6);
        chk("clr_c1", 32'(clear), 32'd1);
        chk("clr_run", 32'(run), 32'd0);
        chk("clr_lap_count", 32'(lap_count), 32'd0);
        tick(1);
        chk("clr_c2", 32'(clear), 32'd1);
        tick(1);
        chk("clr_c3", 32'(clear), 32'd1);
        tick(1);
        chk("clr_done", 32'(clear), 32'd0);
        chk("clr_done_run", 32'(run), 32'd0);
        tick(5);
        chk("clr_start_ignored", 32'(run), 32'd0);
        key_start = 1'b1;
        key_lap   = 1'b1;
        tick(8);
        chk("idle_run", 32'(run), 32'd0);
        chk("idle_clear", 32'(clear), 32'd0);

        // Lap counter wraps 15 -> 0 over 16 lap entries
        hit(1'b1, 1'b0);
        chk("wrap_start_run", 32'(run), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            hit(1'b0, 1'b1);
            chk("wrap_count", 32'(lap_count), 32'(i % 16));
            hit(1'b0, 1'b1);
        end
        chk("wrap_back_running", 32'(lap_active), 32'd0);

        // Reset in LAP: controls drop at once, display goes live
        hit(1'b0, 1'b1);
        chk("pre_rst_lap_active", 32'(lap_active), 32'd1);
        set_time(6'd9, 6'd10, 6'd11, 7'd12);
        reset_n = 1'b0;
        #1;
        chk("rst_lap_run", 32'(run), 32'd0);
        chk("rst_lap_active_now", 32'(lap_active), 32'd0);
        chk("rst_lap_count_now", 32'(lap_count), 32'd0);
        tick(1);
        chk("rst_lap_hour_live", 32'(hour_out), 32'd9);
        chk("rst_lap_minute_live", 32'(minute_out), 32'd10);
        chk("rst_lap_msec_live", 32'(msec_out), 32'd12);
        reset_n = 1'b1;
        tick(2);
        chk("post_rst_run", 32'(run), 32'd0);

        // Reset in CLEAR: clear drops at once, FSM back in IDLE
        key_lap = 1'b0;
        tick(9);
        chk("pre_rst_clear", 32'(clear), 32'd1);
        reset_n = 1'b0;
        key_lap = 1'b1;
        #1;
        chk("rst_clear_now", 32'(clear), 32'd0);
        chk("rst_clear_run", 32'(run), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("post_rst_clear", 32'(clear), 32'd0);
        chk("post_rst_clear_run", 32'(run), 32'd0);
        hit(1'b1, 1'b0);
        chk("idle_to_running", 32'(run), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
